// File: rtl/fpu_round_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fpu_round_pipe
// Purpose  : Two-stage valid/ready IEEE-754 rounding stage for the FPU add/sub
//            datapath. Stage 1 decides the round increment and inexact flag.
//            Stage 2 applies the increment, renormalises on carry-out, promotes
//            subnormals and saturates on overflow.
//            Works for FP32 (EXP_W=8, MAN_W=23) and FP64 (EXP_W=11, MAN_W=52).
// Revision : 1.0 - initial pipelined release
// ============================================================================
module fpu_round_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic                     sign_i,
  input  logic [EXP_W-1:0]         exp_i,
  input  logic [MAN_W:0]           man_i,
  input  logic [1:0]               rs_i,
  input  logic [2:0]               rm_i,
  input  logic                     special_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [EXP_W+MAN_W:0]     result_o,
  output logic [4:0]               fflags_o,
  output logic                     rm_err_o
);

  // RISC-V rounding-mode encodings
  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  localparam int RES_W = 1 + EXP_W + MAN_W;

  // Exponent constants: all-ones (Inf/NaN) and the largest finite exponent
  localparam logic [EXP_W-1:0] EXP_ONES  = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0] EXP_MAXF  = {{(EXP_W-1){1'b1}}, 1'b0};
  localparam logic [EXP_W:0]   EXP_SAT   = {1'b0, {EXP_W{1'b1}}};
  localparam logic [EXP_W:0]   EXP_ONE_X = {{EXP_W{1'b0}}, 1'b1};

  // --------------------------------------------------------------------------
  // Handshake chain
  // --------------------------------------------------------------------------
  logic s1_valid_q;
  logic out_valid_q;
  logic s2_ready;
  logic s1_ready;
  logic s1_load;
  logic s2_load;

  assign s2_ready   = ~out_valid_q | out_ready_i;
  assign s1_ready   = ~s1_valid_q  | s2_ready;
  assign in_ready_o = s1_ready;

  // Flush wins over an input transfer in the same cycle
  assign s1_load = in_valid_i & s1_ready & ~flush_i;
  assign s2_load = s1_valid_q & s2_ready;

  // --------------------------------------------------------------------------
  // Stage 1: decide increment and inexact
  // --------------------------------------------------------------------------
  logic             s1_inc_d;
  logic             s1_nx_d;
  logic [2:0]       s1_mode_d;
  logic             s1_rm_err_d;
  logic             bit_l;
  logic             bit_r;
  logic             bit_s;

  logic             s1_sign_q;
  logic [EXP_W-1:0] s1_exp_q;
  logic [MAN_W:0]   s1_man_q;
  logic             s1_inc_q;
  logic             s1_nx_q;
  logic [2:0]       s1_mode_q;
  logic             s1_special_q;
  logic             s1_rm_err_q;

  // Round-increment decision from L/R/S, sign and the (sanitised) mode
  always_comb begin
    bit_l       = man_i[0];
    bit_r       = rs_i[1];
    bit_s       = rs_i[0];
    s1_rm_err_d = rm_i[2] & (rm_i[1] | rm_i[0]);
    // Reserved encodings behave as round-to-nearest-even
    s1_mode_d   = s1_rm_err_d ? RM_RNE : rm_i;
    s1_nx_d     = bit_r | bit_s;
    s1_inc_d    = 1'b0;
    case (s1_mode_d)
      RM_RNE:  s1_inc_d = bit_r & (bit_l | bit_s);
      RM_RTZ:  s1_inc_d = 1'b0;
      RM_RDN:  s1_inc_d = sign_i & (bit_r | bit_s);
      RM_RUP:  s1_inc_d = ~sign_i & (bit_r | bit_s);
      RM_RMM:  s1_inc_d = bit_r;
      default: s1_inc_d = 1'b0;
    endcase
  end

  // Stage 1 register: valid follows the handshake, payload loads on transfer
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      s1_valid_q   <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_exp_q     <= '0;
      s1_man_q     <= '0;
      s1_inc_q     <= 1'b0;
      s1_nx_q      <= 1'b0;
      s1_mode_q    <= RM_RNE;
      s1_special_q <= 1'b0;
      s1_rm_err_q  <= 1'b0;
    end else begin
      if (flush_i) begin
        s1_valid_q <= 1'b0;
      end else if (s1_ready) begin
        s1_valid_q <= in_valid_i;
      end
      if (s1_load) begin
        s1_sign_q    <= sign_i;
        s1_exp_q     <= exp_i;
        s1_man_q     <= man_i;
        s1_inc_q     <= s1_inc_d;
        s1_nx_q      <= s1_nx_d;
        s1_mode_q    <= s1_mode_d;
        s1_special_q <= special_i;
        s1_rm_err_q  <= s1_rm_err_d;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: apply increment, renormalise, saturate
  // --------------------------------------------------------------------------
  logic [MAN_W+1:0] m_sum;
  logic [MAN_W:0]   m_norm;
  logic [EXP_W:0]   exp_rnd;
  logic             ovf;
  logic             to_inf;
  logic             uf;
  logic             nx;
  logic [EXP_W-1:0] res_exp;
  logic [MAN_W-1:0] res_frac;
  logic [RES_W-1:0] result_d;
  logic [4:0]       fflags_d;

  logic [RES_W-1:0] result_q;
  logic [4:0]       fflags_q;
  logic             rm_err_q;

  // Rounded magnitude and flags for the beat held in stage 1
  always_comb begin
    m_sum = {1'b0, s1_man_q} + {{(MAN_W+1){1'b0}}, s1_inc_q};

    // Carry-out past the hidden bit: shift right one and bump the exponent.
    // The exponent is kept one bit wider so an all-ones input cannot wrap.
    if (m_sum[MAN_W+1]) begin
      m_norm  = m_sum[MAN_W+1:1];
      exp_rnd = {1'b0, s1_exp_q} + EXP_ONE_X;
    end else begin
      m_norm  = m_sum[MAN_W:0];
      exp_rnd = {1'b0, s1_exp_q};
    end

    // A subnormal that rounds up into the hidden bit becomes the smallest normal
    if ((s1_exp_q == '0) && m_norm[MAN_W]) begin
      exp_rnd = EXP_ONE_X;
    end

    ovf = (exp_rnd >= EXP_SAT);

    // Direction decides whether overflow lands on Inf or on max-finite
    case (s1_mode_q)
      RM_RNE:  to_inf = 1'b1;
      RM_RMM:  to_inf = 1'b1;
      RM_RUP:  to_inf = ~s1_sign_q;
      RM_RDN:  to_inf = s1_sign_q;
      default: to_inf = 1'b0;
    endcase

    if (ovf) begin
      res_exp  = to_inf ? EXP_ONES : EXP_MAXF;
      res_frac = to_inf ? '0 : {MAN_W{1'b1}};
    end else begin
      res_exp  = exp_rnd[EXP_W-1:0];
      res_frac = m_norm[MAN_W-1:0];
    end

    nx = s1_nx_q | ovf;
    // Tininess is judged on the incoming exponent only
    uf = (s1_exp_q == '0) & s1_nx_q;

    if (s1_special_q) begin
      result_d = {s1_sign_q, s1_exp_q, s1_man_q[MAN_W-1:0]};
      fflags_d = 5'b00000;
    end else begin
      result_d = {s1_sign_q, res_exp, res_frac};
      fflags_d = {1'b0, 1'b0, ovf, uf, nx};
    end
  end

  // Output register: holds its payload while the consumer stalls
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      fflags_q    <= 5'b00000;
      rm_err_q    <= 1'b0;
    end else begin
      if (flush_i) begin
        out_valid_q <= 1'b0;
      end else if (s2_ready) begin
        out_valid_q <= s1_valid_q;
      end
      if (s2_load) begin
        result_q <= result_d;
        fflags_q <= fflags_d;
        rm_err_q <= s1_rm_err_q;
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign fflags_o    = fflags_q;
  assign rm_err_o    = rm_err_q;

endmodule
`default_nettype wire

// File: tb/tb_fpu_round_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_round_pipe
// Purpose  : Scoreboard bench for fpu_round_pipe (FP32 configuration).
//            Driver pushes expected results at input transfer; an independent
//            monitor pops and compares at each output transfer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpu_round_pipe;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic        sign_i;
  logic [7:0]  exp_i;
  logic [23:0] man_i;
  logic [1:0]  rs_i;
  logic [2:0]  rm_i;
  logic        special_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] result_o;
  logic [4:0]  fflags_o;
  logic        rm_err_o;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  fl;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  int   ready_mode = 0;  // 0 always, 1 toggle, 2 random, 3 held low
  bit   mon_en = 1'b1;

  fpu_round_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .sign_i      (sign_i),
    .exp_i       (exp_i),
    .man_i       (man_i),
    .rs_i        (rs_i),
    .rm_i        (rm_i),
    .special_i   (special_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .result_o    (result_o),
    .fflags_o    (fflags_o),
    .rm_err_o    (rm_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference: rounding from the value of the discarded tail, in quarter-ulps
  function automatic exp_t model(input logic sg, input logic [7:0] e, input logic [23:0] m,
                                 input logic [1:0] rs, input logic [2:0] rm, input logic sp);
    exp_t   r;
    int     mode;
    int     disc;
    int     ex;
    longint sig;
    bit     up;
    bit     nx;
    bit     uf;
    bit     of;
    bit     inf;
    r.err = (rm > 3'd4);
    mode  = r.err ? 0 : int'(rm);
    if (sp) begin
      r.res = {sg, e, m[22:0]};
      r.fl  = 5'b0;
      return r;
    end
    disc = 2 * int'(rs[1]) + int'(rs[0]);
    case (mode)
      0:       up = (disc > 2) || (disc == 2 && m[0]);
      1:       up = 1'b0;
      2:       up = sg && (disc != 0);
      3:       up = !sg && (disc != 0);
      default: up = (disc >= 2);
    endcase
    sig = longint'(m) + longint'(up);
    ex  = int'(e);
    if (sig >= (64'sd1 <<< 24)) begin
      sig = sig / 2;
      ex  = ex + 1;
    end
    if (ex == 0 && sig >= (64'sd1 <<< 23)) ex = 1;
    nx = (disc != 0);
    uf = (e == 8'd0) && nx;
    of = 1'b0;
    if (ex >= 255) begin
      of  = 1'b1;
      nx  = 1'b1;
      inf = (mode == 0) || (mode == 4) || (mode == 3 && !sg) || (mode == 2 && sg);
      r.res = inf ? {sg, 8'hFF, 23'h0} : {sg, 8'hFE, 23'h7FFFFF};
    end else begin
      r.res = {sg, ex[7:0], sig[22:0]};
    end
    r.fl = {2'b00, of, uf, nx};
    return r;
  endfunction

  // Drive one beat starting at a negedge; hold until accepted, then push expectation
  task automatic send(input logic sg, input logic [7:0] e, input logic [23:0] m,
                      input logic [1:0] rs, input logic [2:0] rm, input logic sp,
                      input bit gold, input logic [31:0] gres, input logic [4:0] gfl);
    bit   acc;
    exp_t x;
    acc        = 1'b0;
    sign_i     = sg;
    exp_i      = e;
    man_i      = m;
    rs_i       = rs;
    rm_i       = rm;
    special_i  = sp;
    in_valid_i = 1'b1;
    for (int w = 0; w < 200 && !acc; w++) begin
      #3;
      if (in_ready_o) acc = 1'b1;
      else @(negedge clk_i);
    end
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: in_ready_o stayed 0, expected 1 within 200 cycles");
    end else begin
      x = model(sg, e, m, rs, rm, sp);
      if (gold) begin
        x.res = gres;
        x.fl  = gfl;
      end
      sb_q.push_back(x);
    end
    @(negedge clk_i);
    in_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid_i = 1'b0;
    repeat (n) @(negedge clk_i);
  endtask

  task automatic send_rand();
    logic [7:0]  e;
    logic [23:0] m;
    case ($urandom_range(0, 5))
      0:       e = 8'h00;
      1:       e = 8'hFE;
      2:       e = 8'hFF;
      3:       e = 8'h01;
      default: e = 8'($urandom_range(1, 254));
    endcase
    m[22:0] = ($urandom_range(0, 3) == 0) ? 23'h7FFFFF : 23'($urandom);
    m[23]   = (e != 8'h00);
    send(1'($urandom), e, m, 2'($urandom), 3'($urandom_range(0, 7)),
         ($urandom_range(0, 15) == 0), 1'b0, 32'h0, 5'h0);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && sb_q.size() != 0; i++) @(negedge clk_i);
    #5;
    check("drain_outstanding", 64'(sb_q.size()), 64'd0);
    @(negedge clk_i);
  endtask

  // Consumer ready pattern
  always @(negedge clk_i) begin
    case (ready_mode)
      0:       out_ready_i = 1'b1;
      1:       out_ready_i = ~out_ready_i;
      2:       out_ready_i = 1'($urandom_range(0, 1));
      default: out_ready_i = 1'b0;
    endcase
  end

  // Monitor: compare on output transfer, and check hold-while-stalled
  initial begin : monitor
    exp_t        x;
    bit          prev_stall;
    logic [37:0] prev_word;
    prev_stall = 1'b0;
    prev_word  = '0;
    forever begin
      @(negedge clk_i);
      #3;
      if (!mon_en) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", 64'(out_valid_o), 64'd1);
          check("stall_hold", 64'({result_o, fflags_o, rm_err_o}), 64'(prev_word));
        end
        if (out_valid_o && out_ready_i) begin
          if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_beat: got result %h with empty scoreboard, expected no beat", result_o);
          end else begin
            x = sb_q.pop_front();
            check("result", 64'(result_o), 64'(x.res));
            check("fflags", 64'(fflags_o), 64'(x.fl));
            check("rm_err", 64'(rm_err_o), 64'(x.err));
          end
        end
        prev_stall = out_valid_o && !out_ready_i;
        prev_word  = {result_o, fflags_o, rm_err_o};
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    reset_i     = 1'b1;
    flush_i     = 1'b0;
    in_valid_i  = 1'b0;
    sign_i      = 1'b0;
    exp_i       = 8'h0;
    man_i       = 24'h0;
    rs_i        = 2'b0;
    rm_i        = 3'b0;
    special_i   = 1'b0;
    out_ready_i = 1'b1;
    #1;
    check("rst_out_valid", 64'(out_valid_o), 64'd0);
    check("rst_in_ready", 64'(in_ready_o), 64'd1);
    check("rst_result", 64'(result_o), 64'd0);
    check("rst_fflags", 64'(fflags_o), 64'd0);
    check("rst_rm_err", 64'(rm_err_o), 64'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;
    @(negedge clk_i);

    // Tie to even, with a two-cycle latency check
    send(1'b0, 8'h7F, 24'h800001, 2'b10, 3'b000, 1'b0, 1'b1, 32'h3F800002, 5'b00001);
    #1;
    check("latency_c1", 64'(out_valid_o), 64'd0);
    @(negedge clk_i);
    #1;
    check("latency_c2", 64'(out_valid_o), 64'd1);
    @(negedge clk_i);
    // Carry-out renormalisation
    send(1'b0, 8'h10, 24'hFFFFFF, 2'b11, 3'b000, 1'b0, 1'b1, 32'h08800000, 5'b00001);
    // Overflow to Inf (RUP, +)
    send(1'b0, 8'hFE, 24'hFFFFFF, 2'b11, 3'b011, 1'b0, 1'b1, 32'h7F800000, 5'b00101);
    // Truncation stays at max finite exponent: inexact only
    send(1'b0, 8'hFE, 24'hFFFFFF, 2'b11, 3'b001, 1'b0, 1'b1, 32'h7F7FFFFF, 5'b00001);
    // All-ones exponent under RTZ saturates to max finite
    send(1'b0, 8'hFF, 24'h800000, 2'b00, 3'b001, 1'b0, 1'b1, 32'h7F7FFFFF, 5'b00101);
    // RDN: negative rounds magnitude up, positive truncates
    send(1'b1, 8'h80, 24'h800000, 2'b01, 3'b010, 1'b0, 1'b1, 32'hC0000001, 5'b00001);
    send(1'b0, 8'h80, 24'h800000, 2'b01, 3'b010, 1'b0, 1'b1, 32'h40000000, 5'b00001);
    // Reserved rm rounds as RNE and is flagged (checked via model's err bit)
    send(1'b0, 8'h80, 24'h800001, 2'b10, 3'b110, 1'b0, 1'b1, 32'h40000002, 5'b00001);
    // Subnormal promotion with underflow
    send(1'b0, 8'h00, 24'h7FFFFF, 2'b11, 3'b000, 1'b0, 1'b1, 32'h00800000, 5'b00011);
    // Special bypass
    send(1'b1, 8'hFF, 24'h400000, 2'b11, 3'b011, 1'b1, 1'b1, 32'hFFC00000, 5'b00000);
    drain();

    // Back-to-back with toggling consumer
    ready_mode = 1;
    for (int i = 0; i < 8; i++) send_rand();
    ready_mode = 0;
    drain();

    // Random traffic with random back-pressure
    ready_mode = 2;
    for (int i = 0; i < 300; i++) begin
      idle(int'($urandom_range(0, 3)) == 0 ? int'($urandom_range(1, 2)) : 0);
      send_rand();
    end
    ready_mode = 0;
    drain();

    // Reset with two beats in flight
    ready_mode = 3;
    idle(2);
    send_rand();
    send_rand();
    mon_en  = 1'b0;
    reset_i = 1'b1;
    #1;
    check("midrst_out_valid", 64'(out_valid_o), 64'd0);
    check("midrst_in_ready", 64'(in_ready_o), 64'd1);
    check("midrst_result", 64'(result_o), 64'd0);
    check("midrst_fflags", 64'(fflags_o), 64'd0);
    sb_q.delete();
    @(negedge clk_i);
    reset_i    = 1'b0;
    ready_mode = 0;
    mon_en     = 1'b1;
    idle(5);

    // Flush with two beats in flight
    ready_mode = 3;
    idle(2);
    send_rand();
    send_rand();
    mon_en  = 1'b0;
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    sb_q.delete();
    #1;
    check("flush_out_valid", 64'(out_valid_o), 64'd0);
    check("flush_in_ready", 64'(in_ready_o), 64'd1);
    @(negedge clk_i);
    ready_mode = 0;
    mon_en     = 1'b1;
    idle(5);

    // Flush overrides a simultaneous input transfer
    sign_i     = 1'b0;
    exp_i      = 8'h40;
    man_i      = 24'h812345;
    rs_i       = 2'b10;
    rm_i       = 3'b000;
    special_i  = 1'b0;
    in_valid_i = 1'b1;
    flush_i    = 1'b1;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    flush_i    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("flush_override", 64'(out_valid_o), 64'd0);
      @(negedge clk_i);
    end

    // Pipeline still healthy afterwards
    send(1'b0, 8'h7F, 24'h800001, 2'b10, 3'b000, 1'b0, 1'b1, 32'h3F800002, 5'b00001);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
